mem_ral_responder: RTL and testbench

//  Slave/responder end of the memory bus driven by the RAL testbench agent.

---
 rtl/mem_resp_pkg.sv | 26 ++
 rtl/mem_resp_array.sv | 55 +++++
 rtl/mem_ral_responder.sv | 176 +++++++++++++++++
 tb/tb_mem_ral_responder.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/mem_resp_pkg.sv
// ---------------------------------------------------------------------------
// mem_resp_pkg
// Shared definitions for the memory-bus responder (mem_ral_responder) and
// its storage array (mem_resp_array).
//
// Contents:
//   mem_resp_state_e : responder FSM states IDLE -> WAIT -> RESP -> IDLE
//   OOR_RDATA        : fill bit returned as read data for an out-of-range
//                      address (replicated to the full data width)
//
// The request struct mem_req_t is declared inside mem_ral_responder because
// its field widths follow that module's parameters.
//
// Optional feature macro: MEM_RESP_WSTRB_EN (byte write strobes).
// ---------------------------------------------------------------------------
package mem_resp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } mem_resp_state_e;

    localparam logic OOR_RDATA = '0;

endpackage : mem_resp_pkg

// File: rtl/mem_resp_array.sv
// ---------------------------------------------------------------------------
// mem_resp_array
// MEM_SIZE x DATA_WIDTH register storage with a synchronous byte-enabled
// write port, an asynchronous (combinational) read port and a synchronous
// clear that zeroes every word.
//
// Ports:
//   clk    in   1            clock, all state on posedge
//   clr    in   1            synchronous clear of all words (wins over we)
//   we     in   1            write enable
//   idx    in   IDX_W        word index for both read and write
//   wdata  in   DATA_WIDTH   write data
//   wstrb  in   DATA_WIDTH/8 per-byte write enables
//   rdata  out  DATA_WIDTH   contents of word idx
//
// The caller guarantees idx < MEM_SIZE whenever we is asserted and
// discards rdata for out-of-range indices.
// ---------------------------------------------------------------------------
module mem_resp_array
    import mem_resp_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MEM_SIZE   = 16,
    parameter int unsigned IDX_W      = 4
) (
    input  logic                    clk,
    input  logic                    clr,
    input  logic                    we,
    input  logic [IDX_W-1:0]        idx,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    output logic [DATA_WIDTH-1:0]   rdata
);

    localparam int unsigned STRB_W = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem [MEM_SIZE];

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int unsigned i = 0; i < MEM_SIZE; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            for (int unsigned b = 0; b < STRB_W; b++) begin
                if (wstrb[b]) begin
                    mem[idx][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

    assign rdata = mem[idx];

endmodule : mem_resp_array

// File: rtl/mem_ral_responder.sv
// ---------------------------------------------------------------------------
// mem_ral_responder
// Responder end of the memory bus driven by the RAL agent. Serves
// single-beat reads and writes to a MEM_SIZE-word register array, inserting
// WAIT_STATES wait cycles per access and signalling completion with a
// one-cycle slv_rsp pulse.
//
// Parameters:
//   ADDR_WIDTH   word address width
//   DATA_WIDTH   data width, multiple of 8
//   MEM_SIZE     number of words, <= 2**ADDR_WIDTH
//   WAIT_STATES  wait cycles between accept and response, 0..15
//
// Ports:
//   clk      in   1             clock
//   reset    in   1             synchronous active-low reset
//   req      in   1             request qualifier, sampled only in IDLE
//   wr       in   1             1 = write, 0 = read
//   addr     in   ADDR_WIDTH    word address
//   wdata    in   DATA_WIDTH    write data
//   wstrb    in   DATA_WIDTH/8  byte strobes (only with MEM_RESP_WSTRB_EN)
//   rdata    out  DATA_WIDTH    read data, valid with slv_rsp, held after
//   slv_rsp  out  1             one-cycle completion pulse
//   err      out  1             out-of-range flag, valid with slv_rsp
//
// Optional feature macro: MEM_RESP_WSTRB_EN adds the wstrb port; without it
// every write updates the full word.
// ---------------------------------------------------------------------------
module mem_ral_responder
    import mem_resp_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 8,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned MEM_SIZE    = 16,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req,
    input  logic                    wr,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [DATA_WIDTH-1:0]   wdata,
`ifdef MEM_RESP_WSTRB_EN
    input  logic [DATA_WIDTH/8-1:0] wstrb,
`endif
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic                    slv_rsp,
    output logic                    err
);

    localparam int unsigned          STRB_W    = DATA_WIDTH / 8;
    localparam int unsigned          IDX_W     = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
    localparam logic [ADDR_WIDTH:0]  MEM_LIMIT = (ADDR_WIDTH+1)'(MEM_SIZE);
    localparam logic [3:0]           WAIT_LOAD = 4'(WAIT_STATES - 1);

    typedef struct packed {
        logic                  wr;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
`ifdef MEM_RESP_WSTRB_EN
        logic [STRB_W-1:0]     wstrb;
`endif
    } mem_req_t;

    mem_resp_state_e       state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    mem_req_t              lat_q, lat_d;
    mem_req_t              bus_req, cur_req;
    logic [DATA_WIDTH-1:0] rdata_d;
    logic                  rsp_d, err_d;
    logic                  go_resp;
    logic                  in_range;
    logic                  arr_we;
    logic [STRB_W-1:0]     arr_strb;
    logic [DATA_WIDTH-1:0] arr_rdata;

    always_comb begin
        bus_req       = '0;
        bus_req.wr    = wr;
        bus_req.addr  = addr;
        bus_req.wdata = wdata;
`ifdef MEM_RESP_WSTRB_EN
        bus_req.wstrb = wstrb;
`endif
    end

    // Next state and latch
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lat_d   = lat_q;
        go_resp = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    lat_d = bus_req;
                    if (WAIT_STATES == 0) begin
                        state_d = RESP;
                        go_resp = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = WAIT_LOAD;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                    go_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The access is performed on the edge that enters RESP, so that rdata,
    // err and slv_rsp are all valid during the RESP cycle itself. With zero
    // wait states that edge is the accept edge, so the live bus request is
    // used instead of the (not yet loaded) latch.
    always_comb begin
        cur_req  = (state_q == IDLE) ? bus_req : lat_q;
        in_range = ({1'b0, cur_req.addr} < MEM_LIMIT);
        arr_we   = go_resp && cur_req.wr && in_range;
`ifdef MEM_RESP_WSTRB_EN
        arr_strb = cur_req.wstrb;
`else
        arr_strb = '1;
`endif
        rsp_d   = go_resp;
        err_d   = go_resp ? !in_range : err;
        rdata_d = rdata;
        if (go_resp && !cur_req.wr) begin
            rdata_d = in_range ? arr_rdata : {DATA_WIDTH{OOR_RDATA}};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            lat_q   <= '0;
            rdata   <= '0;
            slv_rsp <= 1'b0;
            err     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lat_q   <= lat_d;
            rdata   <= rdata_d;
            slv_rsp <= rsp_d;
            err     <= err_d;
        end
    end

    mem_resp_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_SIZE   (MEM_SIZE),
        .IDX_W      (IDX_W)
    ) u_array (
        .clk   (clk),
        .clr   (!reset),
        .we    (arr_we),
        .idx   (cur_req.addr[IDX_W-1:0]),
        .wdata (cur_req.wdata),
        .wstrb (arr_strb),
        .rdata (arr_rdata)
    );

endmodule : mem_ral_responder

// File: tb/tb_mem_ral_responder.sv
module tb_mem_ral_responder;

    logic        clk;
    logic        reset;
    logic        req;
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
    logic        slv_rsp;
    logic        err;

    int pass_cnt  = 0;
    int total_cnt = 0;

    mem_ral_responder #(
        .ADDR_WIDTH  (8),
        .DATA_WIDTH  (32),
        .MEM_SIZE    (16),
        .WAIT_STATES (2)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .wr      (wr),
        .addr    (addr),
        .wdata   (wdata),
`ifdef MEM_RESP_WSTRB_EN
        .wstrb   (wstrb),
`endif
        .rdata   (rdata),
        .slv_rsp (slv_rsp),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // One access: drive at a negedge, accepted at the next posedge, then the
    // bus is scrambled and req dropped. lat counts negedges after accept
    // until slv_rsp is seen (WAIT_STATES+1 expected).
    task automatic do_access(input logic w, input logic [7:0] a, input logic [31:0] d,
                             input logic [3:0] s, output logic [31:0] rd, output logic er,
                             output int lat, output logic pulse_ok);
        @(negedge clk);
        req = 1'b1; wr = w; addr = a; wdata = d; wstrb = s;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0; wr = ~w; addr = a ^ 8'h5A; wdata = ~d; wstrb = ~s;
        lat = 1;
        while (!slv_rsp && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        rd = rdata;
        er = err;
        @(negedge clk);
        pulse_ok = !slv_rsp;
    endtask

    typedef struct {
        logic        w;
        logic [7:0]  a;
        logic [31:0] d;
        logic [3:0]  s;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    task automatic run_vec(input vec_t v, input string tag);
        logic [31:0] rd;
        logic        er;
        int          lat;
        logic        pok;
        do_access(v.w, v.a, v.d, v.s, rd, er, lat, pok);
        check({tag, "_latency"}, 32'(lat), 32'd3);
        check({tag, "_rdata"}, rd, v.exp_rd);
        check({tag, "_err"}, {31'd0, er}, {31'd0, v.exp_err});
        check({tag, "_pulse_one_cycle"}, {31'd0, pok}, 32'd1);
    endtask

    initial begin
        vec_t vt[$];
        vec_t v;
        int   p1, p2;
        logic saw_rsp;

        req = 0; wr = 0; addr = '0; wdata = '0; wstrb = '0;

        // Reset and reset-state checks
        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_rdata", rdata, 32'h0);
        check("reset_slv_rsp", {31'd0, slv_rsp}, 32'd0);
        check("reset_err", {31'd0, err}, 32'd0);
        reset = 1'b1;

        // Vector table
        for (int i = 0; i < 16; i++) vt.push_back('{1'b0, 8'(i), 32'h0, 4'hF, 32'h0, 1'b0});
        vt.push_back('{1'b1, 8'd3,   32'hA5A5_0001, 4'hF, 32'h0,         1'b0});
        vt.push_back('{1'b0, 8'd3,   32'h0,         4'hF, 32'hA5A5_0001, 1'b0});
        vt.push_back('{1'b1, 8'd20,  32'hDEAD_DEAD, 4'hF, 32'hA5A5_0001, 1'b1});
        vt.push_back('{1'b0, 8'd20,  32'h0,         4'hF, 32'h0,         1'b1});
        vt.push_back('{1'b0, 8'd4,   32'h0,         4'hF, 32'h0,         1'b0});
        vt.push_back('{1'b1, 8'd15,  32'hCAFE_F00D, 4'hF, 32'h0,         1'b0});
        vt.push_back('{1'b0, 8'd15,  32'h0,         4'hF, 32'hCAFE_F00D, 1'b0});
        vt.push_back('{1'b0, 8'd3,   32'h0,         4'hF, 32'hA5A5_0001, 1'b0});
        vt.push_back('{1'b1, 8'd16,  32'h1111_1111, 4'hF, 32'hA5A5_0001, 1'b1});
        vt.push_back('{1'b0, 8'd0,   32'h0,         4'hF, 32'h0,         1'b0});
        vt.push_back('{1'b0, 8'd255, 32'h0,         4'hF, 32'h0,         1'b1});

        foreach (vt[i]) run_vec(vt[i], $sformatf("vec%0d", i));

        // Held req with bus change during WAIT: first write must go to addr 7,
        // second access (held req) writes addr 8; pulses 4 cycles apart.
        @(negedge clk);
        req = 1'b1; wr = 1'b1; addr = 8'd7; wdata = 32'h0707_0707; wstrb = 4'hF;
        @(posedge clk);
        @(negedge clk);
        addr = 8'd8; wdata = 32'h0808_0808;
        p1 = -1; p2 = -1;
        for (int t = 1; t <= 20 && p2 < 0; t++) begin
            if (t > 1) @(negedge clk);
            if (slv_rsp) begin
                if (p1 < 0) p1 = t;
                else p2 = t;
            end
        end
        req = 1'b0;
        check("held_req_first_latency", 32'(p1), 32'd3);
        check("held_req_pulse_spacing", 32'(p2 - p1), 32'd4);
        run_vec('{1'b0, 8'd7, 32'h0, 4'hF, 32'h0707_0707, 1'b0}, "held_rd7");
        run_vec('{1'b0, 8'd8, 32'h0, 4'hF, 32'h0808_0808, 1'b0}, "held_rd8");

        // Reset during WAIT of a write to addr 5
        @(negedge clk);
        req = 1'b1; wr = 1'b1; addr = 8'd5; wdata = 32'h5555_5555;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        check("midreset_rdata", rdata, 32'h0);
        check("midreset_err", {31'd0, err}, 32'd0);
        saw_rsp = 1'b0;
        for (int t = 0; t < 6; t++) begin
            if (slv_rsp) saw_rsp = 1'b1;
            @(negedge clk);
        end
        check("midreset_no_rsp", {31'd0, saw_rsp}, 32'd0);
        run_vec('{1'b0, 8'd5, 32'h0, 4'hF, 32'h0, 1'b0}, "midreset_rd5");
        run_vec('{1'b0, 8'd3, 32'h0, 4'hF, 32'h0, 1'b0}, "midreset_rd3_cleared");

`ifdef MEM_RESP_WSTRB_EN
        v = '{1'b1, 8'd1, 32'h1122_3344, 4'hF, 32'h0, 1'b0};
        run_vec(v, "strb_full_wr");
        v = '{1'b1, 8'd1, 32'hFFFF_FFFF, 4'b0101, 32'h0, 1'b0};
        run_vec(v, "strb_partial_wr");
        v = '{1'b0, 8'd1, 32'h0, 4'hF, 32'h11FF_33FF, 1'b0};
        run_vec(v, "strb_rd1");
        v = '{1'b1, 8'd1, 32'h0000_0000, 4'b0000, 32'h11FF_33FF, 1'b0};
        run_vec(v, "strb_noop_wr");
        v = '{1'b0, 8'd1, 32'h0, 4'hF, 32'h11FF_33FF, 1'b0};
        run_vec(v, "strb_rd1_after_noop");
`else
        // Without strobes, every write updates the full word.
        v = '{1'b1, 8'd1, 32'h1122_3344, 4'b0101, 32'h0, 1'b0};
        run_vec(v, "full_wr1");
        v = '{1'b0, 8'd1, 32'h0, 4'hF, 32'h1122_3344, 1'b0};
        run_vec(v, "full_rd1");
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule : tb_mem_ral_responder
